// File: rtl/lab3_mem_word_mem_responder.sv
// Word-granular main-memory model on the cache_req/cache_resp val/rdy interface.
// Requests are serviced at accept time; responses return in order after a fixed latency.
module lab3_mem_word_mem_responder #(
  parameter int NUM_WORDS = 256,
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 2,
  parameter int OPAQUE_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cache_req_val,
  output logic                cache_req_rdy,
  input  logic                cache_req_type,
  input  logic [OPAQUE_W-1:0] cache_req_opaque,
  input  logic [31:0]         cache_req_addr,
  input  logic [31:0]         cache_req_data,
  output logic                cache_resp_val,
  input  logic                cache_resp_rdy,
  output logic                cache_resp_type,
  output logic [OPAQUE_W-1:0] cache_resp_opaque,
  output logic [31:0]         cache_resp_data
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CD_W-1:0]  CD_INIT = CD_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic                typ;
    logic [OPAQUE_W-1:0] opq;
    logic [31:0]         data;
  } entry_t;

  logic [31:0]      r_mem [NUM_WORDS];
  entry_t           r_q   [DEPTH];
  logic [CD_W-1:0]  r_cd  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_req_go;
  logic             w_resp_go;
  logic             w_empty;
  logic [IDX_W-1:0] w_idx;
  entry_t           w_head;
  logic             w_unused_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // Byte offset and bits above the storage range are dropped, so addresses alias.
  assign w_idx         = cache_req_addr[IDX_W+1:2];
  assign w_unused_addr = ^{cache_req_addr[31:IDX_W+2], cache_req_addr[1:0]};

  // No bypass: a full queue refuses even if the head leaves this cycle.
  assign cache_req_rdy = (r_count < CNT_MAX);
  assign w_empty       = (r_count == '0);
  assign w_req_go      = cache_req_val && cache_req_rdy;

  assign w_head         = r_q[r_rd_ptr];
  assign cache_resp_val = !w_empty && (r_cd[r_rd_ptr] == '0);
  assign w_resp_go      = cache_resp_val && cache_resp_rdy;

  assign cache_resp_type   = cache_resp_val ? w_head.typ  : 1'b0;
  assign cache_resp_opaque = cache_resp_val ? w_head.opq  : '0;
  assign cache_resp_data   = cache_resp_val ? w_head.data : '0;

  // NOTE: storage and queue payload carry no reset; validity comes solely from
  // the reset-cleared pointers/count, and the outputs are gated by cache_resp_val.
  always_ff @(posedge clk) begin
    if (w_req_go) begin
      if (cache_req_type) begin
        r_mem[w_idx]  <= cache_req_data;
        r_q[r_wr_ptr] <= entry_t'{typ: 1'b1, opq: cache_req_opaque, data: 32'h0};
      end else begin
        // Reads sample the word as it stood before this edge.
        r_q[r_wr_ptr] <= entry_t'{typ: 1'b0, opq: cache_req_opaque, data: r_mem[w_idx]};
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments; the later
  // countdown load on accept deliberately overrides the decrement of that slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_cd[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_cd[i] != '0) r_cd[i] <= r_cd[i] - CD_W'(1);
      end
      if (w_req_go) begin
        r_cd[r_wr_ptr] <= CD_INIT;
        r_wr_ptr       <= ptr_inc(r_wr_ptr);
      end
      if (w_resp_go) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_req_go, w_resp_go})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_mem_word_mem_responder.sv
// Scoreboard bench for lab3_mem_word_mem_responder: expectations are pushed at
// each accepted request from a reference word store and popped as responses leave.
module tb_lab3_mem_word_mem_responder;

  localparam int NUM_WORDS = 256;
  localparam int DEPTH     = 4;
  localparam int LATENCY   = 2;
  localparam int OPAQUE_W  = 8;

  logic                clk;
  logic                reset_n;
  logic                cache_req_val;
  logic                cache_req_rdy;
  logic                cache_req_type;
  logic [OPAQUE_W-1:0] cache_req_opaque;
  logic [31:0]         cache_req_addr;
  logic [31:0]         cache_req_data;
  logic                cache_resp_val;
  logic                cache_resp_rdy;
  logic                cache_resp_type;
  logic [OPAQUE_W-1:0] cache_resp_opaque;
  logic [31:0]         cache_resp_data;

  lab3_mem_word_mem_responder #(
    .NUM_WORDS(NUM_WORDS), .DEPTH(DEPTH), .LATENCY(LATENCY), .OPAQUE_W(OPAQUE_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cache_req_val    (cache_req_val),
    .cache_req_rdy    (cache_req_rdy),
    .cache_req_type   (cache_req_type),
    .cache_req_opaque (cache_req_opaque),
    .cache_req_addr   (cache_req_addr),
    .cache_req_data   (cache_req_data),
    .cache_resp_val   (cache_resp_val),
    .cache_resp_rdy   (cache_resp_rdy),
    .cache_resp_type  (cache_resp_type),
    .cache_resp_opaque(cache_resp_opaque),
    .cache_resp_data  (cache_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                typ;
    logic [OPAQUE_W-1:0] opq;
    logic [31:0]         data;
    int                  acc;
    bit                  lat;
  } exp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  exp_t        sb[$];
  int          pop_cyc[$];
  logic [31:0] model_mem [int];
  bit          head_seen   = 1'b0;
  bit          g_lat       = 1'b0;
  exp_t        mon_e;
  int          mon_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response checker and request recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      head_seen = 1'b0;
    end else begin
      if (cache_resp_val) begin
        if (sb.size() == 0) begin
          check("spurious_resp_val", 32'(cache_resp_val), 32'd0);
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            if (sb[0].lat) check("latency", 32'(cyc - sb[0].acc), 32'(LATENCY));
          end
          check("resp_type",   32'(cache_resp_type),   32'(sb[0].typ));
          check("resp_opaque", 32'(cache_resp_opaque), 32'(sb[0].opq));
          check("resp_data",   cache_resp_data,        sb[0].data);
          if (cache_resp_rdy) begin
            void'(sb.pop_front());
            pop_cyc.push_back(cyc);
            head_seen = 1'b0;
          end
        end
      end
      if (cache_req_val && cache_req_rdy) begin
        mon_idx   = int'((cache_req_addr >> 2) % NUM_WORDS);
        mon_e.typ = cache_req_type;
        mon_e.opq = cache_req_opaque;
        mon_e.acc = cyc;
        mon_e.lat = g_lat;
        if (cache_req_type) begin
          model_mem[mon_idx] = cache_req_data;
          mon_e.data = 32'h0;
        end else begin
          mon_e.data = model_mem.exists(mon_idx) ? model_mem[mon_idx] : 32'h0;
        end
        sb.push_back(mon_e);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until it is accepted; val is left high.
  task automatic send(input logic typ, input logic [7:0] opq,
                      input logic [31:0] addr, input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    cache_req_val    = 1'b1;
    cache_req_type   = typ;
    cache_req_opaque = opq;
    cache_req_addr   = addr;
    cache_req_data   = data;
    for (int i = 0; i < 50; i++) begin
      ok = cache_req_rdy;
      next_cycle();
      if (ok) break;
    end
    check("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    cache_req_val = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !cache_resp_val) break;
      next_cycle();
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    cache_req_val    = 1'b0;
    cache_req_type   = 1'b0;
    cache_req_opaque = '0;
    cache_req_addr   = '0;
    cache_req_data   = '0;
    cache_resp_rdy   = 1'b1;
    repeat (2) next_cycle();
    check("rst_resp_val",    32'(cache_resp_val),    32'd0);
    check("rst_resp_type",   32'(cache_resp_type),   32'd0);
    check("rst_resp_opaque", 32'(cache_resp_opaque), 32'd0);
    check("rst_resp_data",   cache_resp_data,        32'd0);
    reset_n = 1'b1;
    next_cycle();
    check("rst_req_rdy", 32'(cache_req_rdy), 32'd1);

    // Write then read the same word.
    g_lat = 1'b1;
    send(1'b1, 8'd1, 32'h10, 32'hDEADBEEF);
    send(1'b0, 8'd2, 32'h10, 32'h0);
    drain();

    // Stall the consumer until the queue fills.
    g_lat = 1'b0;
    cache_resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 32'h10, 32'h0);
    cache_req_opaque = 8'd4;
    for (int i = 0; i < 3; i++) begin
      check("full_req_rdy", 32'(cache_req_rdy), 32'd0);
      next_cycle();
    end
    cache_resp_rdy = 1'b1;
    send(1'b0, 8'd4, 32'h10, 32'h0);
    drain();

    // Back-to-back reads at full throughput.
    g_lat = 1'b1;
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      check("b2b_req_rdy", 32'(cache_req_rdy), 32'd1);
      send(1'b0, 8'(8'h10 + i), 32'h10, 32'h0);
    end
    drain();
    check("b2b_resp_count", 32'(pop_cyc.size()), 32'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("b2b_consecutive", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));

    // Address aliasing modulo NUM_WORDS*4 and byte offset ignored.
    send(1'b1, 8'h20, 32'h400, 32'hA5A5A5A5);
    send(1'b0, 8'h21, 32'h000, 32'h0);
    send(1'b0, 8'h22, 32'h403, 32'h0);
    drain();

    // Reset with requests in flight.
    g_lat = 1'b0;
    cache_resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 8'(8'h30 + i), 32'h10, 32'h0);
    cache_req_val = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_resp_val", 32'(cache_resp_val), 32'd0);
    #5 reset_n = 1'b1;
    cache_resp_rdy = 1'b1;
    next_cycle();
    check("postrst_req_rdy", 32'(cache_req_rdy), 32'd1);
    repeat (10) next_cycle();
    check("postrst_sb_empty", 32'(sb.size()), 32'd0);
    g_lat = 1'b1;
    send(1'b0, 8'h38, 32'h10, 32'h0);
    drain();

    // Full queue with a dequeue in the same cycle as a new request.
    g_lat = 1'b0;
    cache_resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'(8'h40 + i), 32'h404, 32'h0);
    cache_req_opaque = 8'h44;
    cache_resp_rdy   = 1'b1;
    check("full_pop_req_rdy", 32'(cache_req_rdy), 32'd0);
    next_cycle();
    cache_resp_rdy = 1'b0;
    check("refill_req_rdy", 32'(cache_req_rdy), 32'd1);
    next_cycle();
    cache_req_val = 1'b0;
    check("refill_full", 32'(cache_req_rdy), 32'd0);
    cache_resp_rdy = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
